sw_debounce_sync: RTL and testbench



---
 rtl/sw_debounce_sync_pkg.sv | 14 +
 rtl/sw_debounce_sync_debounce_ch.sv | 122 ++++++++++++
 rtl/sw_debounce_sync.sv | 62 ++++++
 tb/tb_sw_debounce_sync.sv | 131 +++++++++++++
 4 files changed

// File: rtl/sw_debounce_sync_pkg.sv
// Shared constants and FSM encoding for the switch debounce stage.
package sw_debounce_sync_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_e;

    localparam int unsigned DEF_STABLE_CYCLES = 500000;
    localparam int unsigned DEF_CNT_W         = 20;

endpackage

// File: rtl/sw_debounce_sync_debounce_ch.sv
// One switch channel: 2-flop synchroniser, stable-count debounce FSM, level.
// Edge pulses are built only when DEBOUNCE_EDGE_OUT_EN is defined.
module debounce_ch
    import sw_debounce_sync_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             smp;

    assign smp = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], raw};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE_LO: begin
                if (smp) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!smp) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!smp) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (smp) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

`ifdef DEBOUNCE_EDGE_OUT_EN
    logic rise_q, rise_d, fall_q, fall_d;

    // Pulses register alongside the level so they coincide with its new value.
    always_comb begin
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce_sync.sv
// Debounces SW[0] (data) and SW[1] (flip-flop clock) and maps them to LEDs.
// DEBOUNCE_EDGE_OUT_EN enables clk_rise/clk_fall and the sticky LEDR[3:2].
module sw_debounce_sync
    import sw_debounce_sync_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] SW,
    output logic       d_clean,
    output logic       clk_clean,
    output logic       clk_rise,
    output logic       clk_fall,
    output logic [3:0] LEDR
);

    logic d_rise_unused, d_fall_unused;

    debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_data (
        .clk   (CLOCK_50),
        .rst   (reset),
        .raw   (SW[0]),
        .level (d_clean),
        .rise  (d_rise_unused),
        .fall  (d_fall_unused)
    );

    debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_gate (
        .clk   (CLOCK_50),
        .rst   (reset),
        .raw   (SW[1]),
        .level (clk_clean),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

`ifdef DEBOUNCE_EDGE_OUT_EN
    logic rise_sticky_q, rise_sticky_d, fall_sticky_q, fall_sticky_d;

    always_comb begin
        rise_sticky_d = rise_sticky_q | clk_rise;
        fall_sticky_d = fall_sticky_q | clk_fall;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rise_sticky_q <= 1'b0;
            fall_sticky_q <= 1'b0;
        end else begin
            rise_sticky_q <= rise_sticky_d;
            fall_sticky_q <= fall_sticky_d;
        end
    end

    assign LEDR = {fall_sticky_q, rise_sticky_q, clk_clean, d_clean};
`else
    assign LEDR = {2'b00, clk_clean, d_clean};
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with STABLE_CYCLES=4, CNT_W=3.
module tb_sw_debounce_sync;

`ifdef DEBOUNCE_EDGE_OUT_EN
    localparam logic EN = 1'b1;
`else
    localparam logic EN = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic [1:0] SW;
    logic       d_clean, clk_clean, clk_rise, clk_fall;
    logic [3:0] LEDR;

    int tests = 0;
    int fails = 0;
    int pulses;

    sw_debounce_sync #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .SW        (SW),
        .d_clean   (d_clean),
        .clk_clean (clk_clean),
        .clk_rise  (clk_rise),
        .clk_fall  (clk_fall),
        .LEDR      (LEDR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {d_clean, clk_clean, clk_rise, clk_fall, LEDR};
    endfunction

    initial begin
        reset = 1'b1;
        SW    = 2'b00;
        repeat (3) step();
        chk("reset_state", outs(), 8'h00);
        reset = 1'b0;

        // Idle low: nothing moves.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_low", outs(), 8'h00);
        end

        // Clean rise on SW[1].
        SW = 2'b10;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("rise_level", {7'd0, clk_clean}, {7'd0, i >= 6});
            chk("rise_pulse", {6'd0, clk_rise, clk_fall}, {6'd0, EN && i == 6, 1'b0});
            chk("rise_sticky", {4'd0, LEDR}, {4'd0, 1'b0, EN && i >= 7, i >= 6, 1'b0});
        end

        // Clean fall on SW[1].
        SW = 2'b00;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("fall_level", {7'd0, clk_clean}, {7'd0, i < 6});
            chk("fall_pulse", {6'd0, clk_rise, clk_fall}, {6'd0, 1'b0, EN && i == 6});
            chk("fall_sticky", {4'd0, LEDR[3:2]}, {6'd0, EN && i >= 7, EN});
        end

        // Bounce 1,0,1,0 then settle high.
        for (int i = 0; i < 4; i++) begin
            SW = (i % 2 == 0) ? 2'b10 : 2'b00;
            step();
            chk("bounce_hold", {7'd0, clk_clean}, 8'd0);
        end
        SW = 2'b10;
        pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (clk_rise) pulses++;
            chk("bounce_level", {7'd0, clk_clean}, {7'd0, i >= 6});
        end
        chk("bounce_one_pulse", 8'(pulses), 8'(EN ? 1 : 0));

        // Short data pulse is filtered.
        SW = 2'b11;
        repeat (3) step();
        SW = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("short_pulse", {7'd0, d_clean}, 8'd0);
        end

        // Reset mid-WAIT_HI discards the pending change.
        reset = 1'b1;
        SW = 2'b00;
        repeat (3) step();
        chk("reset_clear", outs(), 8'h00);
        reset = 1'b0;
        repeat (2) step();
        SW = 2'b11;
        repeat (5) step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_wait_reset", outs(), 8'h00);
        end
        reset = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("post_reset_levels", {6'd0, d_clean, clk_clean}, {6'd0, i >= 6, i >= 6});
            chk("post_reset_pulse", {7'd0, clk_rise}, {7'd0, EN && i == 6});
            chk("post_reset_led", {4'd0, LEDR}, {4'd0, 1'b0, EN && i >= 7, i >= 6, i >= 6});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
